// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial-side status of the UART frame transmitter.
// The master supplies the byte, the request and the parity setup; the slave returns the line and busy.
interface uart_tx_frame_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  parity_enable;
   logic                  parity_type;
   logic                  tx_out;
   logic                  busy;

   modport master (
      output p_data,
      output data_valid,
      output parity_enable,
      output parity_type,
      input  tx_out,
      input  busy
   );

   modport slave (
      input  p_data,
      input  data_valid,
      input  parity_enable,
      input  parity_type,
      output tx_out,
      output busy
   );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// One serial bit per rising edge of the bit-rate clock; tx_out and busy are registered.
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8
) (
   input  logic              clk_based_on_prescale,
   input  logic              asy_reset,
   uart_tx_frame_if.slave    bus
);
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   logic [2:0]            state_r,    state_s;
   logic [CNT_W-1:0]      cnt_r,      cnt_s;
   logic [CNT_W-1:0]      cnt_nxt_s;
   logic [DATA_WIDTH-1:0] data_r,     data_s;
   logic                  par_en_r,   par_en_s;
   logic                  par_type_r, par_type_s;
   logic                  tx_out_r,   tx_out_s;
   logic                  busy_r,     busy_s;

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   assign cnt_nxt_s = cnt_r + CNT_W'(1);

   // Next state and the registered line value for the bit about to be presented.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      data_s     = data_r;
      par_en_s   = par_en_r;
      par_type_s = par_type_r;
      tx_out_s   = tx_out_r;
      busy_s     = busy_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.data_valid) begin
               data_s     = bus.p_data;
               par_en_s   = bus.parity_enable;
               par_type_s = bus.parity_type;
               state_s    = ST_START;
               tx_out_s   = 1'b0;
               busy_s     = 1'b1;
            end else begin
               state_s    = ST_IDLE;
               tx_out_s   = 1'b1;
               busy_s     = 1'b0;
            end
         end
         ST_START: begin
            state_s  = ST_DATA;
            cnt_s    = '0;
            tx_out_s = data_r[0];
            busy_s   = 1'b1;
         end
         ST_DATA: begin
            busy_s = 1'b1;
            if (cnt_r == LAST_BIT) begin
               cnt_s = '0;
               if (par_en_r) begin
                  state_s  = ST_PARITY;
                  tx_out_s = parity_bit(data_r, par_type_r);
               end else begin
                  state_s  = ST_STOP;
                  tx_out_s = 1'b1;
               end
            end else begin
               cnt_s    = cnt_nxt_s;
               tx_out_s = data_r[cnt_nxt_s];
            end
         end
         ST_PARITY: begin
            state_s  = ST_STOP;
            tx_out_s = 1'b1;
            busy_s   = 1'b1;
         end
         ST_STOP: begin
            // Returning to IDLE guarantees one idle-level cycle before the next start bit.
            state_s  = ST_IDLE;
            tx_out_s = 1'b1;
            busy_s   = 1'b0;
         end
         default: begin
            state_s  = ST_IDLE;
            cnt_s    = '0;
            tx_out_s = 1'b1;
            busy_s   = 1'b0;
         end
      endcase
   end

   // State, latched frame configuration and output registers.
   always_ff @(posedge clk_based_on_prescale or posedge asy_reset) begin
      if (asy_reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= '0;
         data_r     <= '0;
         par_en_r   <= 1'b0;
         par_type_r <= 1'b0;
         tx_out_r   <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         data_r     <= data_s;
         par_en_r   <= par_en_s;
         par_type_r <= par_type_s;
         tx_out_r   <= tx_out_s;
         busy_r     <= busy_s;
      end
   end

   assign bus.tx_out = tx_out_r;
   assign bus.busy   = busy_r;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: hand-computed serial sequences checked bit by bit on the falling edge.
module tb_uart_tx_frame;
   logic clk;
   logic asy_reset;
   int   errors;
   int   checks;

   uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

   uart_tx_frame #(.DATA_WIDTH(8)) dut (
      .clk_based_on_prescale (clk),
      .asy_reset             (asy_reset),
      .bus                   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Caller stands on the falling edge where the start bit should be visible.
   // exp[i] is the i-th serial bit; pulse_at >= 0 drives a one-cycle data_valid pulse mid-frame.
   task automatic check_frame(input logic [11:0] exp, input int n, input string tag, input int pulse_at);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_tx%0d", tag, i), bus.tx_out, exp[i]);
         chk($sformatf("%s_busy%0d", tag, i), bus.busy, 1'b1);
         if (pulse_at >= 0) bus.data_valid = (i == pulse_at);
         @(negedge clk);
      end
      chk($sformatf("%s_idle_tx", tag), bus.tx_out, 1'b1);
      chk($sformatf("%s_idle_busy", tag), bus.busy, 1'b0);
   endtask

   // Request one frame, then scramble the live inputs so only latched values can produce exp.
   task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [11:0] exp, input int n, input string tag, input int pulse_at);
      bus.p_data        = d;
      bus.parity_enable = pe;
      bus.parity_type   = pt;
      bus.data_valid    = 1'b1;
      @(negedge clk);
      bus.data_valid    = 1'b0;
      bus.p_data        = ~d;
      bus.parity_enable = ~pe;
      bus.parity_type   = ~pt;
      check_frame(exp, n, tag, pulse_at);
   endtask

   initial begin
      errors            = 0;
      checks            = 0;
      asy_reset         = 1'b1;
      bus.p_data        = 8'h00;
      bus.data_valid    = 1'b0;
      bus.parity_enable = 1'b0;
      bus.parity_type   = 1'b0;

      @(negedge clk);
      chk("reset_tx", bus.tx_out, 1'b1);
      chk("reset_busy", bus.busy, 1'b0);
      @(negedge clk);
      asy_reset = 1'b0;
      @(negedge clk);
      chk("post_reset_tx", bus.tx_out, 1'b1);
      chk("post_reset_busy", bus.busy, 1'b0);

      // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1 -> busy for 11 cycles
      send_frame(8'hA5, 1'b1, 1'b0, 12'b0_1_0_10100101_0, 11, "a5_even", -1);
      send_frame(8'hA5, 1'b1, 1'b1, 12'b0_1_1_10100101_0, 11, "a5_odd", -1);
      send_frame(8'h80, 1'b1, 1'b0, 12'b0_1_1_10000000_0, 11, "80_even", -1);
      send_frame(8'h80, 1'b1, 1'b1, 12'b0_1_0_10000000_0, 11, "80_odd", -1);
      // No parity: start, eight zeros, stop -> 10 cycles
      send_frame(8'h00, 1'b0, 1'b0, 12'b00_1_00000000_0, 10, "00_nopar", -1);

      // data_valid held across the frame, p_data changed mid-frame
      bus.p_data        = 8'h81;
      bus.parity_enable = 1'b1;
      bus.parity_type   = 1'b0;
      bus.data_valid    = 1'b1;
      @(negedge clk);
      bus.p_data = 8'h3C;
      check_frame(12'b0_1_0_10000001_0, 11, "held_first", -1);
      @(negedge clk);
      bus.data_valid = 1'b0;
      check_frame(12'b0_1_0_00111100_0, 11, "held_second", -1);

      // data_valid pulse while busy: no effect, no extra frame
      send_frame(8'h5A, 1'b1, 1'b0, 12'b0_1_0_01011010_0, 11, "busy_pulse", 4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("no_extra_tx%0d", i), bus.tx_out, 1'b1);
         chk($sformatf("no_extra_busy%0d", i), bus.busy, 1'b0);
      end

      // Reset during DATA bit 4 of 0xA5 (bit 4 is 0)
      bus.p_data        = 8'hA5;
      bus.parity_enable = 1'b1;
      bus.parity_type   = 1'b0;
      bus.data_valid    = 1'b1;
      @(negedge clk);
      bus.data_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_bit4_tx", bus.tx_out, 1'b0);
      chk("pre_rst_bit4_busy", bus.busy, 1'b1);
      #2 asy_reset = 1'b1;
      #1;
      chk("rst_async_tx", bus.tx_out, 1'b1);
      chk("rst_async_busy", bus.busy, 1'b0);
      @(negedge clk);
      asy_reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("after_rst_tx%0d", i), bus.tx_out, 1'b1);
         chk($sformatf("after_rst_busy%0d", i), bus.busy, 1'b0);
      end

      // First acceptance after reset behaves normally
      send_frame(8'h0F, 1'b1, 1'b1, 12'b0_1_1_00001111_0, 11, "after_rst_frame", -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_frame.md
UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 clk_based_on_prescale  input  1  bit-rate clock; one serial bit is emitted per rising edge.
REQ-003 asy_reset  input  1  asynchronous, active-high reset.
REQ-004 p_data  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 data_valid  input  1  request to send p_data; sampled on rising edges.
REQ-006 parity_enable  input  1  1 = insert a parity bit, 0 = no parity bit.
REQ-007 parity_type  input  1  0 = even parity, 1 = odd parity.
REQ-008 tx_out  output  1  serial line; idle level 1.
REQ-009 busy  output  1  1 while a frame is in progress.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; tx_out and busy SHALL be registered outputs.
REQ-011 In IDLE: tx_out = 1, busy = 0.
REQ-012 Acceptance: on an edge where state = IDLE and data_valid = 1, the block SHALL latch p_data, parity_enable and parity_type into internal registers, go to START, drive tx_out = 0 and drive busy = 1.
REQ-013 START SHALL last 1 cycle, then go to DATA.
REQ-014 DATA SHALL last DATA_WIDTH cycles; tx_out SHALL carry the latched data LSB first.
REQ-015 A bit counter SHALL run 0..DATA_WIDTH-1 in DATA and clear on leaving DATA.
REQ-016 After the last data bit, the FSM SHALL go to PARITY if latched parity_enable = 1, else to STOP.
REQ-017 PARITY SHALL last 1 cycle and drive tx_out = XOR-reduction of the latched data (even), or its inverse (odd).
REQ-018 STOP SHALL last 1 cycle with tx_out = 1, then go to IDLE, where busy returns to 0.
REQ-019 Frame length on tx_out: DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 without.
REQ-020 data_valid and all inputs SHALL be ignored while busy = 1; a request held through a frame is accepted in the first IDLE cycle after STOP.
REQ-021 Minimum spacing SHALL be one IDLE cycle (tx_out = 1) between the end of STOP and the next START.
REQ-022 Changes to p_data, parity_enable or parity_type after acceptance SHALL NOT affect the frame in progress.
REQ-023 Parity SHALL be computed from the latched data only, never from live p_data.

Reset
REQ-024 When asy_reset = 1, the block SHALL immediately, without a clock edge, force state = IDLE, tx_out = 1 and busy = 0, and clear the bit counter, data register and latched configuration.
REQ-025 A reset during any state SHALL abort the frame with no further frame bits.
REQ-026 After reset deassertion, the first acceptance SHALL follow REQ-012.

Verification
REQ-027 p_data=0xA5, parity_enable=1, parity_type=0, pulse data_valid -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1; busy high for exactly 11 cycles.
REQ-028 p_data=0xA5, parity_type=1 -> parity bit = 1; p_data=0x80, parity_type=0 -> parity bit = 1; p_data=0x80, parity_type=1 -> parity bit = 0.
REQ-029 p_data=0x00, parity_enable=0 -> tx_out 0, eight 0s, then 1; frame is 10 cycles and busy drops afterwards.
REQ-030 Hold data_valid=1 continuously with p_data changed to 0x3C mid-frame -> first frame is unaltered, one idle cycle (tx_out=1) follows, then a second frame carries 0x3C.
REQ-031 Assert asy_reset during DATA bit 4 -> tx_out=1 and busy=0 immediately; after release with data_valid=0, the line stays at 1.
REQ-032 data_valid pulse while busy=1 -> no effect on the current frame and no extra frame after it.
